uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller between the UART receiver and the APB register file.
//  Buffers received bytes in a DEPTH-entry show-ahead FIFO and gates reception with rx_en.
//  Flags overrun, the FIFO reaching a fill threshold, and a character-idle timeout.
//  The APB side drains the FIFO by popping bytes.
// PARAMETERS
//  DEPTH          16   FIFO entries; power of 2, 2..256
//  TIMEOUT_CHARS  4    idle char-times (10 bit-times each) before timeout_irq; 1..255
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous reset, active-high
//  rx_en        in   1        1 = accept bytes from receiver
//  baud_div     in   16       clocks per bit (same value the receiver uses); 0 = timeout disabled
//  rx_data      in   8        byte from receiver
//  rx_valid     in   1        1-cycle strobe, rx_data valid
//  flush        in   1        1-cycle pulse: empty FIFO
//  pop          in   1        1-cycle pulse: consume head byte
//  rx_thresh    in   CW       threshold level; 0 = disabled
//  overrun_clr  in   1        1-cycle pulse: clear overrun
//  pop_data     out  8        FIFO head byte; valid when !empty
//  fifo_count   out  CW       bytes held; CW = $clog2(DEPTH)+1
//  empty        out  1        fifo_count == 0
//  full         out  1        fifo_count == DEPTH
//  thresh_irq   out  1        level: fifo_count >= rx_thresh, and rx_thresh != 0
//  timeout_irq  out  1        sticky level, see timeout FSM
//  overrun      out  1        sticky: a byte was dropped because FIFO full
// BEHAVIOUR
//  Reset
//  - Outputs: empty=1; everything else 0, including pop_data and the FIFO pointers.
//  - Timeout FSM enters IDLE.
//  - Reset mid-operation discards FIFO contents immediately.
//  FIFO
//  - push = rx_valid & rx_en & !flush; byte written at the clk edge.
//  - count/empty/full/pop_data reflect the push on the next cycle.
//  - pop is honoured only if !empty. A pop when empty is ignored: no change, no error.
//  - Push with pop on the same cycle:
//    - Both act if !empty; count unchanged.
//    - If full, the push is accepted (the pop frees the slot) and overrun is not set.
//    - If empty, only the push acts.
//  - Push when full without pop: byte dropped; overrun <= 1.
//  - Pointers are ADDR_W=$clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates by construction.
//  - rx_en=0: incoming bytes discarded silently (no overrun). Stored bytes stay poppable.
//  - flush has highest priority:
//    - Next cycle count=0 and pointers=0.
//    - A same-cycle rx_valid byte is dropped with no overrun; a same-cycle pop is ignored.
//    - overrun is unaffected.
//  - overrun_clr clears overrun. If an overrun event coincides with overrun_clr, set wins.
//  - thresh_irq is combinational from the count register (no extra latency).
//  Timeout FSM
//  - 32-bit idle counter; limit L = baud_div * 10 * TIMEOUT_CHARS, computed in 32 bits.
//  - IDLE: FIFO empty or baud_div == 0; counter held at 0.
//    - -> COUNT when !empty and baud_div != 0.
//  - COUNT: counter increments every clk.
//    - Any push or honoured pop restarts the counter at 0.
//    - -> EXPIRED when counter == L-1 (timeout_irq rises L cycles after the last activity).
//    - -> IDLE when the FIFO becomes empty, on flush, or when baud_div becomes 0.
//  - EXPIRED: timeout_irq = 1.
//    - -> COUNT (counter 0) on push or honoured pop, if !empty afterwards.
//    - -> IDLE on empty or flush.
//  - timeout_irq = 1 only in EXPIRED, registered.
//  - A baud_div change while in COUNT takes effect on the next compare.
// TESTING
//  1. Push 0x55, 0xA3 (rx_en=1) -> count=2, pop_data=0x55; pop -> pop_data=0xA3, count=1; pop -> empty=1.
//  2. Fill 16 bytes, push 0x77 -> full=1, overrun=1, 0x77 lost.
//     Then overrun_clr -> overrun=0.
//     Then, full, push+pop same cycle -> count=16, overrun=0.
//  3. rx_thresh=4; push 3 -> thresh_irq=0; 4th push -> thresh_irq=1 next cycle; pop -> thresh_irq=0.
//  4. baud_div=8, TIMEOUT_CHARS=4; push 1 byte, then idle -> timeout_irq=1 exactly 320 cycles after push.
//     Then pop -> timeout_irq=0, empty=1.
//  5. Count=5 with flush and rx_valid on the same cycle -> count=0, byte dropped, overrun unchanged.
//     Same check with pop on an empty FIFO -> no change.
//  6. rx_en=0 with rx_valid pulses -> count stays 0, overrun=0.
//     Assert rst mid-fill (count=9) -> empty=1, all irqs 0 immediately.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side byte FIFO with rx gating, overrun, fill-threshold and idle-timeout flags.
module uart_rx_ctrl #(
    parameter int DEPTH = 16,
    parameter int TIMEOUT_CHARS = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_en,
    input  logic [15:0]   baud_div,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          flush,
    input  logic          pop,
    input  logic [CW-1:0] rx_thresh,
    input  logic          overrun_clr,
    output logic [7:0]    pop_data,
    output logic [CW-1:0] fifo_count,
    output logic          empty,
    output logic          full,
    output logic          thresh_irq,
    output logic          timeout_irq,
    output logic          overrun
);
    typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;
    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    logic [31:0]   idle_cnt, limit;
    logic          push_req, do_push, do_pop, ovf, act;
    assign empty      = fifo_count == '0;
    assign full       = fifo_count == CW'(DEPTH);
    assign push_req   = rx_valid & rx_en & ~flush;
    assign do_pop     = pop & ~empty & ~flush;
    // when full, a same-cycle pop frees the slot the push needs
    assign do_push    = push_req & (~full | do_pop);
    assign ovf        = push_req & full & ~do_pop;
    assign act        = do_push | do_pop;
    assign count_nxt  = flush ? '0 : fifo_count + CW'(do_push) - CW'(do_pop);
    assign pop_data   = empty ? 8'h00 : mem[rd_ptr];
    assign thresh_irq = (rx_thresh != '0) && (fifo_count >= rx_thresh);
    assign limit      = 32'(baud_div) * 32'(10 * TIMEOUT_CHARS);
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rx_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_nxt;
            overrun    <= ovf | (overrun & ~overrun_clr);
        end
    end
    // idle timer: state decisions use the post-edge fill level so the count starts on the activity edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            timeout_irq <= 1'b0;
        end else begin
            timeout_irq <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (count_nxt != '0 && baud_div != '0) state <= COUNT;
                end
                COUNT: begin
                    if (count_nxt == '0 || baud_div == '0) begin
                        state    <= IDLE;
                        idle_cnt <= '0;
                    end else if (act) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == limit - 32'd1) begin
                        state       <= EXPIRED;
                        idle_cnt    <= '0;
                        timeout_irq <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                EXPIRED: begin
                    if (count_nxt == '0) begin
                        state <= IDLE;
                    end else if (act) begin
                        state    <= COUNT;
                        idle_cnt <= '0;
                    end else begin
                        timeout_irq <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized checks of uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int TC = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    logic          clk = 1'b0;
    logic          rst, rx_en, rx_valid, flush, pop, overrun_clr;
    logic [15:0]   baud_div;
    logic [7:0]    rx_data, pop_data;
    logic [CW-1:0] rx_thresh, fifo_count;
    logic          empty, full, thresh_irq, timeout_irq, overrun;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [7:0]    q[$];
    bit            m_ovr;
    int            since;
    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CHARS(TC)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .baud_div(baud_div), .rx_data(rx_data),
        .rx_valid(rx_valid), .flush(flush), .pop(pop), .rx_thresh(rx_thresh),
        .overrun_clr(overrun_clr), .pop_data(pop_data), .fifo_count(fifo_count),
        .empty(empty), .full(full), .thresh_irq(thresh_irq), .timeout_irq(timeout_irq),
        .overrun(overrun)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_all(input string tag);
        int lim;
        lim = int'(baud_div) * 10 * TC;
        check({tag, ".count"}, 32'(fifo_count), q.size());
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".data"}, 32'(pop_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
        check({tag, ".thresh"}, 32'(thresh_irq), 32'(rx_thresh != 0 && q.size() >= int'(rx_thresh)));
        check({tag, ".timeout"}, 32'(timeout_irq), 32'(baud_div != 0 && q.size() != 0 && since >= lim));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    endtask
    // model: flush empties; otherwise pop first, then push if room remains, else overrun
    task automatic tick(input string tag);
        bit pop_ok, pushed, ovr_set;
        pop_ok = 0;
        pushed = 0;
        ovr_set = 0;
        if (flush) q.delete();
        else begin
            pop_ok = pop && q.size() != 0;
            if (pop_ok) void'(q.pop_front());
            if (rx_valid && rx_en) begin
                if (q.size() < DEPTH) begin
                    q.push_back(rx_data);
                    pushed = 1;
                end else ovr_set = 1;
            end
        end
        if (overrun_clr) m_ovr = 0;
        if (ovr_set) m_ovr = 1;
        since = (pop_ok || pushed) ? 0 : (since < 1000000 ? since + 1 : since);
        @(posedge clk);
        #1;
        rx_valid = 0;
        pop = 0;
        flush = 0;
        overrun_clr = 0;
        check_all(tag);
    endtask
    task automatic push(input logic [7:0] b);
        rx_valid = 1;
        rx_data = b;
        tick("push");
    endtask
    task automatic do_pop();
        pop = 1;
        tick("pop");
    endtask
    initial begin
        int first;
        rst = 1; rx_en = 0; rx_valid = 0; flush = 0; pop = 0; overrun_clr = 0;
        baud_div = 0; rx_data = 0; rx_thresh = 0;
        m_ovr = 0; since = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;
        rx_en = 1;
        push(8'h55);
        push(8'hA3);
        check("t1.count2", 32'(fifo_count), 32'd2);
        check("t1.head55", 32'(pop_data), 32'h55);
        do_pop();
        check("t1.headA3", 32'(pop_data), 32'hA3);
        do_pop();
        check("t1.empty", 32'(empty), 32'd1);
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        push(8'h77);
        check("t2.full", 32'(full), 32'd1);
        check("t2.ovr", 32'(overrun), 32'd1);
        overrun_clr = 1;
        tick("ovrclr");
        check("t2.ovrclr", 32'(overrun), 32'd0);
        rx_valid = 1; rx_data = 8'h3C; pop = 1;
        tick("fullpp");
        check("t2.pp_count", 32'(fifo_count), 32'd16);
        check("t2.pp_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) do_pop();
        rx_thresh = 4;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        check("t3.below", 32'(thresh_irq), 32'd0);
        push(8'h11);
        check("t3.at", 32'(thresh_irq), 32'd1);
        do_pop();
        check("t3.after_pop", 32'(thresh_irq), 32'd0);
        flush = 1;
        tick("flush");
        rx_thresh = 0;
        baud_div = 8;
        push(8'hC4);
        first = 0;
        for (int i = 1; i <= 400 && first == 0; i++) begin
            tick("idle");
            if (timeout_irq) first = i;
        end
        check("t4.latency", 32'(first), 32'd320);
        do_pop();
        check("t4.irq_clr", 32'(timeout_irq), 32'd0);
        check("t4.empty", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        flush = 1; rx_valid = 1; rx_data = 8'hEE;
        tick("flushpush");
        check("t5.count", 32'(fifo_count), 32'd0);
        check("t5.ovr", 32'(overrun), 32'd0);
        pop = 1;
        tick("popempty");
        rx_en = 0;
        for (int i = 0; i < 5; i++) push(8'($urandom));
        check("t6.count", 32'(fifo_count), 32'd0);
        rx_en = 1;
        rx_thresh = 4;
        for (int i = 0; i < 9; i++) push(8'($urandom));
        rst = 1;
        #1;
        q.delete(); m_ovr = 0; since = 0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 0;
        check_all("post_rst");
        for (int ph = 0; ph < 4; ph++) begin
            baud_div = (ph == 0) ? 16'd0 : ((ph == 2) ? 16'd2 : 16'd1);
            flush = 1;
            tick("phase");
            for (int b = 0; b < 15; b++) begin
                int pp, pq;
                pp = $urandom_range(0, 100);
                pq = $urandom_range(0, 100);
                rx_thresh = CW'($urandom_range(0, DEPTH));
                for (int c = 0; c < 100; c++) begin
                    rx_valid = ($urandom_range(0, 99) < pp);
                    rx_data = 8'($urandom);
                    rx_en = ($urandom_range(0, 7) != 0);
                    pop = ($urandom_range(0, 99) < pq);
                    flush = ($urandom_range(0, 199) == 0);
                    overrun_clr = ($urandom_range(0, 29) == 0);
                    tick("rand");
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
